// File: rtl/xs3_pkg.sv
// Shared types and constants for the excess-3 digit sequencer.
package xs3_pkg;

  localparam int DIGIT_W    = 4;
  localparam int XS3_CODE_W = 5;
  localparam int XS3_OFFSET = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/xs3_digit_sequencer_nibble_xs3.sv
// Combinational nibble to excess-3 converter: code = digit + XS3_OFFSET.
// The result is one bit wider than the digit, so 15+3 does not wrap.
module nibble_xs3
  import xs3_pkg::*;
(
  input  logic [DIGIT_W-1:0]    i_digit,
  output logic [XS3_CODE_W-1:0] o_code
);

  assign o_code = {1'b0, i_digit} + XS3_CODE_W'(XS3_OFFSET);

endmodule

// File: rtl/xs3_digit_sequencer.sv
// Word-to-digit sequencer: accepts a packed word on a valid/ready input,
// then emits one registered excess-3 code per digit, least significant
// digit first, on a valid/ready output with a last-digit marker.
//
// Handshake rule, both ports: a transfer happens on a rising clock edge
// where valid and ready are both 1. Valid never depends on ready in the
// same cycle, and the output payload holds stable while valid && !ready.
//
// Optional feature macro: XS3_BCD_CHECK_EN. When defined, out_err flags
// digits above 9. When undefined, out_err is tied to 0.
module xs3_digit_sequencer
  import xs3_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [XS3_CODE_W-1:0]         out_code,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          out_err,
  output logic                          busy
);

  localparam int WORD_W = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [WORD_W-1:0]       r_word;
  logic [CNT_W-1:0]        r_idx;
  logic [XS3_CODE_W-1:0]   r_code;
  logic                    r_last;

  logic                    w_accept;
  logic                    w_advance;
  logic                    w_load;
  logic [WORD_W-1:0]       w_sel_word;
  logic [CNT_W-1:0]        w_sel_idx;
  logic [DIGIT_W-1:0]      w_digit;
  logic [XS3_CODE_W-1:0]   w_code;

  // Load events: a new word in IDLE, or a non-final digit handshake in SEND.
  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_advance = (r_state == SEND) && out_ready && (r_idx != LAST_IDX);
  assign w_load    = w_accept || w_advance;

  // The single converter looks at the digit that becomes current next:
  // digit 0 of the incoming word, or the following digit of the held word.
  assign w_sel_word = w_accept ? in_data : r_word;
  assign w_sel_idx  = w_accept ? '0 : (r_idx + CNT_W'(1));

  // Digit select mux; an out-of-range index (past the last digit) reads 0.
  always_comb begin
    w_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_sel_idx == CNT_W'(i)) begin
        w_digit = w_sel_word[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  nibble_xs3 u_nibble_xs3 (
    .i_digit (w_digit),
    .o_code  (w_code)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && (r_idx == LAST_IDX)) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Word, index and registered output payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
      r_code <= '0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_word <= in_data;
      r_idx  <= '0;
      r_code <= w_code;
      r_last <= (NUM_DIGITS == 1);
    end else if (w_advance) begin
      r_idx  <= w_sel_idx;
      r_code <= w_code;
      r_last <= (w_sel_idx == LAST_IDX);
    end
  end

  assign out_code = r_code;
  assign out_last = r_last;

`ifdef XS3_BCD_CHECK_EN
  logic r_err;

  // Non-BCD flag, loaded together with the code it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_load) begin
      r_err <= (w_digit > 4'd9);
    end
  end

  assign out_err = r_err;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_xs3_digit_sequencer.sv
// Testbench for xs3_digit_sequencer: a 4-digit instance carries the
// word-level scenarios, a 1-digit instance covers the single-digit case.
module tb_xs3_digit_sequencer;

`ifdef XS3_BCD_CHECK_EN
  localparam bit BCD_CHK = 1'b1;
`else
  localparam bit BCD_CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-digit instance
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_code;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_err;
  logic        busy;

  // 1-digit instance
  logic [3:0]  s_in_data;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [4:0]  s_out_code;
  logic        s_out_valid;
  logic        s_out_ready;
  logic        s_out_last;
  logic        s_out_err;
  logic        s_busy;

  xs3_digit_sequencer #(.NUM_DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_err   (out_err),
    .busy      (busy)
  );

  xs3_digit_sequencer #(.NUM_DIGITS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (s_in_data),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .out_code  (s_out_code),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_last  (s_out_last),
    .out_err   (s_out_err),
    .busy      (s_busy)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {last, err, code[4:0]}
  logic [6:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [6:0] exp_entry(input logic [3:0] d, input bit last);
    logic [4:0] code;
    code = {1'b0, d} + 5'd3;
    return {last, (BCD_CHK && (d > 4'd9)), code};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge with the DUT in IDLE. Sends one word, optionally
  // stalls out_ready for stall_cycles on digit stall_digit, and consumes
  // digits until all are done or stop_after digits have been taken.
  // Returns at a negedge.
  task automatic run_word(input logic [15:0] data, input int stall_digit,
                          input int stall_cycles, input int stop_after);
    int got;
    int stalls;
    int budget;
    logic [6:0] e;
    logic [6:0] act;
    got = 0;
    stalls = 0;
    budget = 0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL in_ready_before_word data=%h act=%b exp=1", data, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_entry(data[i*4 +: 4], (i == 3)));
    end
    in_data  = data;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom_range(0, 65535));
    while (got < 4 && got != stop_after && budget < 40) begin
      budget++;
      act = {out_last, out_err, out_code};
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL digit_valid data=%h digit=%0d act_valid=%b act_busy=%b exp=1",
                 data, got, out_valid, busy);
        break;
      end
      if (got == stall_digit && stalls < stall_cycles) begin
        out_ready = 1'b0;
        stalls++;
        checks++;
        if (act !== exp_q[0]) begin
          failures++;
          $display("FAIL stall_hold data=%h digit=%0d act=%b exp=%b", data, got, act, exp_q[0]);
        end
      end else begin
        out_ready = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL digit data=%h digit=%0d act{last,err,code}=%b exp=%b", data, got, act, e);
        end
        got++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (budget >= 40) begin
      checks++;
      failures++;
      $display("FAIL timeout data=%h digits_seen=%0d exp=4", data, got);
    end
    if (got == 4) begin
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_word data=%h act_in_ready=%b out_valid=%b busy=%b exp=1/0/0",
                 data, in_ready, out_valid, busy);
      end
    end
    if (stop_after < 0) exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    s_in_data = '0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready act=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid act=%b exp=0", out_valid); end
    checks++;
    if (out_code !== 5'd0) begin failures++; $display("FAIL reset_out_code act=%0d exp=0", out_code); end
    checks++;
    if (out_last !== 1'b0 || out_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags act_last=%b err=%b busy=%b exp=0", out_last, out_err, busy);
    end
    checks++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_out_code !== 5'd0) begin
      failures++;
      $display("FAIL reset_single act_in_ready=%b out_valid=%b code=%0d exp=1/0/0",
               s_in_ready, s_out_valid, s_out_code);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_word(16'h1234, -1, 0, -1);
  endtask

  task automatic test_boundary();
    run_word(16'h9000, -1, 0, -1);
    run_word(16'hFFFF, -1, 0, -1);
  endtask

  task automatic test_backpressure();
    run_word(16'h0052, 1, 3, -1);
    run_word(16'h8765, 3, 2, -1);
  endtask

  task automatic test_invalid_bcd();
    run_word(16'h00A0, -1, 0, -1);
    run_word(16'hB9FA, 0, 1, -1);
  endtask

  task automatic test_reset_mid_word();
    run_word(16'h4321, -1, 0, 2);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_valid act_valid=%b busy=%b exp=0", out_valid, busy);
    end
    checks++;
    if (out_code !== 5'd0 || out_last !== 1'b0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_payload act_code=%0d last=%b err=%b exp=0", out_code, out_last, out_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_release act_in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
    end
    run_word(16'h0007, -1, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 4; w++) begin
      run_word(16'($urandom_range(0, 65535)), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 2)), -1);
    end
  endtask

  task automatic test_single_digit();
    logic [6:0] e;
    logic [3:0] vals[2];
    vals[0] = 4'h5;
    vals[1] = 4'hC;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (s_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL single_in_ready act=%b exp=1", s_in_ready);
      end
      exp_q.push_back(exp_entry(vals[k], 1'b1));
      s_in_data   = vals[k];
      s_in_valid  = 1'b1;
      s_out_ready = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (s_out_valid !== 1'b1 || {s_out_last, s_out_err, s_out_code} !== e) begin
        failures++;
        $display("FAIL single_code digit=%h act_valid=%b act=%b exp_valid=1 exp=%b",
                 vals[k], s_out_valid, {s_out_last, s_out_err, s_out_code}, e);
      end
      @(negedge clk);
      checks++;
      if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL single_done act_valid=%b in_ready=%b exp=0/1", s_out_valid, s_in_ready);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_backpressure();
    test_invalid_bcd();
    test_reset_mid_word();
    test_back_to_back();
    test_single_digit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
